// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU serial frame receiver.
package alu_pkg;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CTL  = 1'b1
    } packet_type_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam int ERR_OP   = 0;
    localparam int ERR_CRC  = 1;
    localparam int ERR_DATA = 2;

    // x^4 + x + 1, leading term implicit
    localparam logic [3:0] CRC4_POLY = 4'b0011;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = d ^ c[3];
        return {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    endfunction

    function automatic logic is_valid_op(input logic [2:0] o);
        logic ok;
        case (o)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_frame_rx_if.sv
// Decoded-operation output bus of the frame receiver (valid/ready plus overrun).
interface alu_frame_rx_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [2:0]        op;
    logic [2:0]        err;
    logic              overrun;

    modport master (
        output out_valid, a_data, b_data, op, err, overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid, a_data, b_data, op, err, overrun,
        output out_ready
    );
endinterface

// File: rtl/alu_crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1) accumulator with synchronous clear and enable.
module alu_crc4_serial
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [3:0] crc
);

    // Shift one bit into the CRC; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc4_step(crc, d);
        end
    end

endmodule

// File: rtl/alu_frame_rx.sv
// Serial frame receiver: assembles B/A operands and a CTL packet from sin,
// checks byte count, CRC and opcode, and presents one decoded operation on
// a valid/ready bus. Optional macro ALU_RX_TIMEOUT_EN enables discarding a
// partial frame after TIMEOUT_CYC idle cycles between packets.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | line idle, waiting for start bit (sin==0)
//   S_TYPE    | sampling packet type bit
//   S_PAYLOAD | sampling 8 payload bits, MSB first
//   S_STOP    | sampling stop bit; accept packet or drop frame
module alu_frame_rx
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sin,
    alu_frame_rx_if.master out_if
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(2 * NBYTES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 * NBYTES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * NBYTES + 1);

    if (DATA_W < 8 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("alu_frame_rx: DATA_W must be a multiple of 8 >= 8, TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TYPE    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_STOP    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    packet_type_t        ptype;
    logic [2:0]          bit_cnt;
    logic [7:0]          payload;
    logic [2*DATA_W-1:0] shreg;
    logic [CNT_W-1:0]    byte_cnt;
    logic [3:0]          crc;

    logic crc_en, crc_d;
    logic data_done, ctl_done, frame_drop, timeout, frame_clr;
    logic [2:0] err_nxt;

    logic              out_valid_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        op_q, err_q;
    logic              overrun_q;

    // Bit-level FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-bit strobes. CTL feeds the CRC a constant 1 on
    // payload bit 7, then the three op bits as they arrive.
    always_comb begin
        state_nxt  = state;
        crc_en     = 1'b0;
        crc_d      = sin;
        data_done  = 1'b0;
        ctl_done   = 1'b0;
        frame_drop = 1'b0;
        case (state)
            S_IDLE: begin
                if (!sin) state_nxt = S_TYPE;
            end
            S_TYPE: begin
                state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (ptype == PKT_DATA) begin
                    crc_en = 1'b1;
                end else if (bit_cnt == 3'd0) begin
                    crc_en = 1'b1;
                    crc_d  = 1'b1;
                end else if (bit_cnt <= 3'd3) begin
                    crc_en = 1'b1;
                end
                if (bit_cnt == 3'd7) state_nxt = S_STOP;
            end
            S_STOP: begin
                state_nxt = S_IDLE;
                if (!sin || (ptype == PKT_CTL && payload[7])) begin
                    frame_drop = 1'b1;
                end else if (ptype == PKT_DATA) begin
                    data_done = 1'b1;
                end else begin
                    ctl_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Packet type, bit counter and payload byte capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptype   <= PKT_DATA;
            bit_cnt <= '0;
            payload <= '0;
        end else begin
            if (state == S_TYPE) begin
                ptype   <= sin ? PKT_CTL : PKT_DATA;
                bit_cnt <= '0;
            end
            if (state == S_PAYLOAD) begin
                payload <= {payload[6:0], sin};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef ALU_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;

    // Idle down-counter; reloads whenever the line is not idling mid-frame.
    always_ff @(posedge clk) begin
        if (!rst_n || state != S_IDLE || byte_cnt == '0 || !sin) begin
            idle_cnt <= TO_W'(TIMEOUT_CYC);
        end else if (idle_cnt != TO_W'(1)) begin
            idle_cnt <= idle_cnt - TO_W'(1);
        end
    end

    assign timeout = (state == S_IDLE) && sin && (byte_cnt != '0) && (idle_cnt == TO_W'(1));
`else
    assign timeout = 1'b0;
`endif

    assign frame_clr = frame_drop || ctl_done || timeout;

    alu_crc4_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_clr),
        .en    (crc_en),
        .d     (crc_d),
        .crc   (crc)
    );

    // Operand shift register and saturating byte count.
    always_ff @(posedge clk) begin
        if (!rst_n || frame_clr) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (data_done) begin
            shreg <= {shreg[2*DATA_W-9:0], payload};
            if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // Error vector for the frame ending at this CTL stop bit, in priority order.
    always_comb begin
        err_nxt = '0;
        if (byte_cnt != CNT_FULL) begin
            err_nxt[ERR_DATA] = 1'b1;
        end else if (crc != payload[3:0]) begin
            err_nxt[ERR_CRC] = 1'b1;
        end else if (!is_valid_op(payload[6:4])) begin
            err_nxt[ERR_OP] = 1'b1;
        end
    end

    // Output register: latch on completed frame unless a held result is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            err_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (ctl_done && out_valid_q && !out_if.out_ready) begin
                overrun_q <= 1'b1;
            end else if (ctl_done) begin
                out_valid_q <= 1'b1;
                a_q         <= shreg[DATA_W-1:0];
                b_q         <= shreg[2*DATA_W-1:DATA_W];
                op_q        <= payload[6:4];
                err_q       <= err_nxt;
            end else if (out_valid_q && out_if.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.a_data    = a_q;
    assign out_if.b_data    = b_q;
    assign out_if.op        = op_q;
    assign out_if.err       = err_q;
    assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_alu_frame_rx.sv
// Scoreboard bench for alu_frame_rx: a 32-bit and a 16-bit instance share
// one clock; expected decodes are queued at stimulus time and popped by a
// monitor on every valid/ready handshake.
module tb_alu_frame_rx;
    import alu_pkg::*;

    localparam int TO16 = 20;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin32 = 1'b1;
    logic sin16 = 1'b1;

    int total = 0;
    int bad = 0;
    int ovr32 = 0;
    int ovr16 = 0;
    exp_t q32[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    alu_frame_rx_if #(.DATA_W(32)) ifc32 ();
    alu_frame_rx_if #(.DATA_W(16)) ifc16 ();

    alu_frame_rx #(.DATA_W(32)) dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin32),
        .out_if (ifc32)
    );

    alu_frame_rx #(.DATA_W(16), .TIMEOUT_CYC(TO16)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin16),
        .out_if (ifc16)
    );

    function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
        logic fb;
        fb = d ^ c[3];
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [2:0] err);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.err = err;
        if (sel == 0) q32.push_back(e);
        else          q16.push_back(e);
    endtask

    task automatic send_bit(input int sel, input logic b);
        if (sel == 0) sin32 = b;
        else          sin16 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int sel, input logic typ, input logic [7:0] byt);
        send_bit(sel, 1'b0);
        send_bit(sel, typ);
        for (int i = 7; i >= 0; i--) send_bit(sel, byt[i]);
        send_bit(sel, 1'b1);
    endtask

    task automatic send_frame(input int sel, input int w, input logic [31:0] b,
                              input logic [31:0] a, input logic [2:0] op, input logic [3:0] flip);
        logic [3:0] c;
        c = 4'h0;
        for (int i = w - 1; i >= 0; i--) c = crc_bit(c, b[i]);
        for (int i = w - 1; i >= 0; i--) c = crc_bit(c, a[i]);
        c = crc_bit(c, 1'b1);
        for (int i = 2; i >= 0; i--) c = crc_bit(c, op[i]);
        for (int k = w / 8 - 1; k >= 0; k--) send_pkt(sel, 1'b0, b[k*8 +: 8]);
        for (int k = w / 8 - 1; k >= 0; k--) send_pkt(sel, 1'b0, a[k*8 +: 8]);
        send_pkt(sel, 1'b1, {1'b0, op, c ^ flip});
    endtask

    task automatic check_out(input int sel, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [2:0] err);
        exp_t e;
        logic empty;
        total++;
        empty = (sel == 0) ? (q32.size() == 0) : (q16.size() == 0);
        if (empty) begin
            bad++;
            $display("FAIL unexpected_frame dut%0d: got a=%h b=%h op=%b err=%b, none expected",
                     sel == 0 ? 32 : 16, a, b, op, err);
        end else begin
            if (sel == 0) e = q32.pop_front();
            else          e = q16.pop_front();
            if (a !== e.a || b !== e.b || op !== e.op || err !== e.err) begin
                bad++;
                $display("FAIL frame dut%0d: got a=%h b=%h op=%b err=%b expected a=%h b=%h op=%b err=%b",
                         sel == 0 ? 32 : 16, a, b, op, err, e.a, e.b, e.op, e.err);
            end
        end
    endtask

    // Monitor: compare on each accepted output, count overrun pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ifc32.out_valid && ifc32.out_ready)
                    check_out(0, ifc32.a_data, ifc32.b_data, ifc32.op, ifc32.err);
                if (ifc16.out_valid && ifc16.out_ready)
                    check_out(1, {16'h0, ifc16.a_data}, {16'h0, ifc16.b_data}, ifc16.op, ifc16.err);
                if (ifc32.overrun) ovr32++;
                if (ifc16.overrun) ovr16++;
            end
        end
    end

    initial begin
        ifc32.out_ready = 1'b1;
        ifc16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check_eq("rst_out_valid", {31'h0, ifc32.out_valid}, 32'h0);
        check_eq("rst_a_data", ifc32.a_data, 32'h0);
        check_eq("rst_b_data", ifc32.b_data, 32'h0);
        check_eq("rst_op_err", {26'h0, ifc32.op, ifc32.err}, 32'h0);
        check_eq("rst_overrun", {31'h0, ifc32.overrun}, 32'h0);

        // 1: good ADD frame, one-cycle visibility and drop after acceptance
        push(0, 32'h1, 32'h2, 3'b100, 3'b000);
        send_frame(0, 32, 32'h2, 32'h1, 3'b100, 4'h0);
        check_eq("latency_valid", {31'h0, ifc32.out_valid}, 32'h1);
        @(posedge clk); #1;
        check_eq("valid_drop", {31'h0, ifc32.out_valid}, 32'h0);

        // 2: corrupted CRC field
        push(0, 32'h1, 32'h2, 3'b100, 3'b010);
        send_frame(0, 32, 32'h2, 32'h1, 3'b100, 4'h1);

        // 3: three data bytes only, then a clean frame
        push(0, 32'h0011_2233, 32'h0, 3'b100, 3'b100);
        send_pkt(0, 1'b0, 8'h11);
        send_pkt(0, 1'b0, 8'h22);
        send_pkt(0, 1'b0, 8'h33);
        send_pkt(0, 1'b1, 8'h40);
        push(0, 32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 3'b000);
        send_frame(0, 32, 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 4'h0);

        // 4: illegal opcode with correct CRC
        push(0, 32'h3, 32'h5, 3'b010, 3'b001);
        send_frame(0, 32, 32'h5, 32'h3, 3'b010, 4'h0);

        // 5: held output, second frame overruns
        @(posedge clk); #1;
        ifc32.out_ready = 1'b0;
        push(0, 32'h2222_2222, 32'h1111_1111, 3'b001, 3'b000);
        send_frame(0, 32, 32'h1111_1111, 32'h2222_2222, 3'b001, 4'h0);
        send_frame(0, 32, 32'h3, 32'h4, 3'b100, 4'h0);
        check_eq("overrun_pulse", {31'h0, ifc32.overrun}, 32'h1);
        check_eq("held_valid", {31'h0, ifc32.out_valid}, 32'h1);
        @(posedge clk); #1;
        check_eq("overrun_single", {31'h0, ifc32.overrun}, 32'h0);
        ifc32.out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("held_drop", {31'h0, ifc32.out_valid}, 32'h0);

        // 6: reset mid-frame, then a full AND frame
        send_pkt(0, 1'b0, 8'hAA);
        send_pkt(0, 1'b0, 8'h55);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("midreset_valid", {31'h0, ifc32.out_valid}, 32'h0);
        push(0, 32'hFFFF_FFFF, 32'h0, 3'b000, 3'b000);
        send_frame(0, 32, 32'h0, 32'hFFFF_FFFF, 3'b000, 4'h0);

        // 16-bit instance: plain decode, then an idle gap after one byte
        push(1, 32'h0000_00AB, 32'h0000_1234, 3'b101, 3'b000);
        send_frame(1, 16, 32'h1234, 32'h00AB, 3'b101, 4'h0);
        send_pkt(1, 1'b0, 8'h5A);
        repeat (TO16) send_bit(1, 1'b1);
`ifdef ALU_RX_TIMEOUT_EN
        push(1, 32'h0000_00F0, 32'h0000_0F0F, 3'b001, 3'b000);
`else
        push(1, 32'h0000_00F0, 32'h0000_0F0F, 3'b001, 3'b100);
`endif
        send_frame(1, 16, 32'h0F0F, 32'h00F0, 3'b001, 4'h0);

        for (int i = 0; i < 200 && (q32.size() != 0 || q16.size() != 0); i++) @(posedge clk);
        #1;
        check_eq("q32_drained", q32.size(), 32'h0);
        check_eq("q16_drained", q16.size(), 32'h0);
        check_eq("overrun_count32", ovr32, 32'h1);
        check_eq("overrun_count16", ovr16, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
